// File: rtl/sccb_read.sv
// SCCB/I2C register read master: writes the register address, restarts, then reads one byte.
// SCL runs at CLK/4; each bit spans quarter cycles q0..q3 (SCL high in q1/q2).
module sccb_read #(
    parameter int GAP_CYCLES = 8
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [15:0] data_in,
    input  logic        SCCB_req,
    output logic        SCCB_SCL,
    output logic        SCCB_SDA_O,
    output logic        SCCB_SDA_OE,
    input  logic        SCCB_SDA_I,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic        SCCB_busy
);
    typedef enum logic [3:0] {
        IDLE, START1, ADDR_W, REG, STOP1, GAP, START2, ADDR_R, READ, NA, STOP2
    } state_t;

    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

    state_t     state_q, state_d;
    logic [1:0] qtr_q, qtr_d;
    logic [3:0] bit_q, bit_d;
    logic [7:0] gap_q, gap_d;
    logic [6:0] id_q, id_d;
    logic [7:0] reg_q, reg_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] rd_data_q, rd_data_d;
    logic       rd_valid_q, rd_valid_d;
    logic       busy_q, busy_d;
    logic       scl_q, scl_d;
    logic       sda_o_q, sda_o_d;
    logic       sda_oe_q, sda_oe_d;
    logic       last_qtr_s;
    logic       bit_scl_s;
    logic [7:0] tx_byte_s;
    logic       unused_id_lsb_s;

    // The R/W bit is forced by the phase, so the ID LSB from data_in is never used.
    assign unused_id_lsb_s = data_in[8];
    assign last_qtr_s      = (qtr_q == 2'd3);
    assign bit_scl_s       = qtr_d[0] ^ qtr_d[1];
    assign tx_byte_s       = (state_d == REG) ? reg_d : {id_d, (state_d == ADDR_R)};

    // Sequencing of states, quarter/bit/gap counters and the read datapath.
    always_comb begin
        state_d    = state_q;
        qtr_d      = qtr_q + 2'd1;
        bit_d      = bit_q;
        gap_d      = gap_q;
        id_d       = id_q;
        reg_d      = reg_q;
        shift_d    = shift_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        busy_d     = busy_q;
        case (state_q)
            IDLE: begin
                qtr_d = 2'd0;
                bit_d = 4'd0;
                gap_d = 8'd0;
                if (SCCB_req) begin
                    id_d    = data_in[15:9];
                    reg_d   = data_in[7:0];
                    busy_d  = 1'b1;
                    state_d = START1;
                end else begin
                    busy_d  = 1'b0;
                end
            end
            START1, START2: begin
                if (last_qtr_s) begin
                    state_d = (state_q == START1) ? ADDR_W : ADDR_R;
                    bit_d   = 4'd0;
                end else begin
                    bit_d   = bit_q;
                end
            end
            ADDR_W, REG, ADDR_R: begin
                if (last_qtr_s && (bit_q == 4'd8)) begin
                    state_d = (state_q == ADDR_W) ? REG : ((state_q == REG) ? STOP1 : READ);
                    bit_d   = 4'd0;
                end else if (last_qtr_s) begin
                    bit_d   = bit_q + 4'd1;
                end else begin
                    bit_d   = bit_q;
                end
            end
            READ: begin
                if (qtr_q == 2'd2) begin
                    shift_d = {shift_q[6:0], SCCB_SDA_I};
                end else begin
                    shift_d = shift_q;
                end
                if (last_qtr_s && (bit_q == 4'd7)) begin
                    state_d = NA;
                    bit_d   = 4'd8;
                end else if (last_qtr_s) begin
                    bit_d   = bit_q + 4'd1;
                end else begin
                    bit_d   = bit_q;
                end
            end
            NA: begin
                if (last_qtr_s) begin
                    state_d = STOP2;
                    bit_d   = 4'd0;
                end else begin
                    bit_d   = bit_q;
                end
            end
            STOP1: begin
                if (last_qtr_s) begin
                    state_d = GAP;
                    gap_d   = 8'd0;
                end else begin
                    gap_d   = gap_q;
                end
            end
            GAP: begin
                qtr_d = 2'd0;
                if (gap_q == GAP_LAST) begin
                    state_d = START2;
                    gap_d   = 8'd0;
                end else begin
                    gap_d   = gap_q + 8'd1;
                end
            end
            STOP2: begin
                if (last_qtr_s) begin
                    state_d    = IDLE;
                    rd_data_d  = shift_q;
                    rd_valid_d = 1'b1;
                    busy_d     = 1'b0;
                end else begin
                    rd_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Bus levels for the cycle being entered, so SCL/SDA come straight from flops.
    always_comb begin
        scl_d    = 1'b1;
        sda_o_d  = 1'b1;
        sda_oe_d = 1'b1;
        case (state_d)
            START1, START2: begin
                sda_o_d = ~qtr_d[1];
            end
            STOP1, STOP2: begin
                scl_d   = (qtr_d != 2'd0);
                sda_o_d = qtr_d[1];
            end
            ADDR_W, REG, ADDR_R: begin
                scl_d = bit_scl_s;
                if (bit_d == 4'd8) begin
                    sda_o_d  = 1'b1;
                    sda_oe_d = 1'b0;
                end else begin
                    sda_o_d  = tx_byte_s[3'd7 - bit_d[2:0]];
                    sda_oe_d = 1'b1;
                end
            end
            READ: begin
                scl_d    = bit_scl_s;
                sda_oe_d = 1'b0;
            end
            NA: begin
                scl_d = bit_scl_s;
            end
            default: begin
                scl_d = 1'b1;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            qtr_q      <= 2'd0;
            bit_q      <= 4'd0;
            gap_q      <= 8'd0;
            id_q       <= 7'd0;
            reg_q      <= 8'd0;
            shift_q    <= 8'd0;
            rd_data_q  <= 8'd0;
            rd_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            scl_q      <= 1'b1;
            sda_o_q    <= 1'b1;
            sda_oe_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            qtr_q      <= qtr_d;
            bit_q      <= bit_d;
            gap_q      <= gap_d;
            id_q       <= id_d;
            reg_q      <= reg_d;
            shift_q    <= shift_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            busy_q     <= busy_d;
            scl_q      <= scl_d;
            sda_o_q    <= sda_o_d;
            sda_oe_q   <= sda_oe_d;
        end
    end

    assign SCCB_SCL    = scl_q;
    assign SCCB_SDA_O  = sda_o_q;
    assign SCCB_SDA_OE = sda_oe_q;
    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign SCCB_busy   = busy_q;

endmodule

// File: tb/tb_sccb_read.sv
// Bench for sccb_read: a bus monitor and slave model decode SCL/SDA into START/STOP/9-bit frames,
// compared with the transaction sequence expected from the request and slave byte.
`timescale 1ns/1ps
module tb_sccb_read;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] data_in;
    logic [2:0]  req;
    logic [2:0]  scl, sda_o, sda_oe, valid, busy;
    logic [7:0]  rd0, rd1, rd2;
    logic        sda_i0, sda_i1, sda_i2;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    // slave / monitor state for DUT 0
    logic        slave_out = 1'b1;
    logic        slave_en  = 1'b0;
    logic [7:0]  slave_q[$];
    logic [7:0]  slave_byte = 8'hFF;
    int          tok_q[$];
    logic        bus0;

    assign bus0   = (sda_oe[0] ? sda_o[0] : 1'b1) & slave_out;
    assign sda_i0 = bus0;
    assign sda_i1 = sda_oe[1] ? sda_o[1] : 1'b1;
    assign sda_i2 = sda_oe[2] ? sda_o[2] : 1'b1;

    sccb_read #(.GAP_CYCLES(8)) u_dut0 (
        .CLK(clk), .RST_N(rst_n), .data_in(data_in), .SCCB_req(req[0]),
        .SCCB_SCL(scl[0]), .SCCB_SDA_O(sda_o[0]), .SCCB_SDA_OE(sda_oe[0]), .SCCB_SDA_I(sda_i0),
        .rd_data(rd0), .rd_valid(valid[0]), .SCCB_busy(busy[0]));
    sccb_read #(.GAP_CYCLES(1)) u_dut1 (
        .CLK(clk), .RST_N(rst_n), .data_in(data_in), .SCCB_req(req[1]),
        .SCCB_SCL(scl[1]), .SCCB_SDA_O(sda_o[1]), .SCCB_SDA_OE(sda_oe[1]), .SCCB_SDA_I(sda_i1),
        .rd_data(rd1), .rd_valid(valid[1]), .SCCB_busy(busy[1]));
    sccb_read #(.GAP_CYCLES(255)) u_dut2 (
        .CLK(clk), .RST_N(rst_n), .data_in(data_in), .SCCB_req(req[2]),
        .SCCB_SCL(scl[2]), .SCCB_SDA_O(sda_o[2]), .SCCB_SDA_OE(sda_oe[2]), .SCCB_SDA_I(sda_i2),
        .rd_data(rd2), .rd_valid(valid[2]), .SCCB_busy(busy[2]));

    // Bus monitor plus slave: sampled mid-cycle, slave changes SDA only after SCL falls.
    initial begin
        logic       prev_scl, prev_sda, rd_phase;
        logic [8:0] sh;
        int         bit_n, frame_n;
        prev_scl = 1'b1; prev_sda = 1'b1; rd_phase = 1'b0; sh = 9'd0; bit_n = 0; frame_n = 0;
        forever begin
            @(negedge clk);
            if (prev_scl && scl[0] && prev_sda && !bus0) begin
                tok_q.push_back(-1);
                bit_n = 0; frame_n = 0; rd_phase = 1'b0;
            end else if (prev_scl && scl[0] && !prev_sda && bus0) begin
                tok_q.push_back(-2);
            end else if (!prev_scl && scl[0]) begin
                sh = {sh[7:0], bus0};
                bit_n++;
                if (bit_n == 9) begin
                    tok_q.push_back(int'(sh));
                    if (frame_n == 0) rd_phase = sh[1];
                    frame_n++;
                    bit_n = 0;
                end
            end else if (prev_scl && !scl[0]) begin
                if (slave_en && rd_phase && frame_n == 1 && bit_n < 8) begin
                    if (bit_n == 0) slave_byte = (slave_q.size() > 0) ? slave_q.pop_front() : 8'hFF;
                    slave_out = slave_byte[7 - bit_n];
                end else begin
                    slave_out = 1'b1;
                end
            end
            prev_scl = scl[0];
            prev_sda = bus0;
        end
    end

    function automatic string tok_str(input int q[$]);
        string s = "";
        foreach (q[i]) begin
            if (q[i] == -1)      s = {s, "S "};
            else if (q[i] == -2) s = {s, "P "};
            else                 s = {s, $sformatf("%03h ", q[i][8:0])};
        end
        return s;
    endfunction

    // Expected bus: START, ID+W, reg, STOP, START, ID+R, data+NA, STOP (released ACK slots read 1).
    function automatic string model_bus(input logic [15:0] d, input logic [7:0] rbyte);
        int q[$];
        q.push_back(-1);
        q.push_back(int'({d[15:9], 1'b0, 1'b1}));
        q.push_back(int'({d[7:0], 1'b1}));
        q.push_back(-2);
        q.push_back(-1);
        q.push_back(int'({d[15:9], 1'b1, 1'b1}));
        q.push_back(int'({rbyte, 1'b1}));
        q.push_back(-2);
        return tok_str(q);
    endfunction

    // start + two 9-bit frames + stop + gap + start + two 9-bit frames + stop, 4 clocks per bit
    function automatic int model_latency(input int g);
        return 4 + 2 * 9 * 4 + 4 + g + 4 + 2 * 9 * 4 + 4;
    endfunction

    task automatic run_txn(input logic [15:0] d, input int poke_at,
                           output int lat, output logic [7:0] got, output int nv);
        @(negedge clk);
        tok_q.delete();
        data_in = d;
        req[0]  = 1'b1;
        @(posedge clk); #1;
        req[0] = 1'b0;
        lat = -1; got = 8'd0; nv = 0;
        for (int n = 1; n <= 600; n++) begin
            @(posedge clk); #1;
            req[0] = (n == poke_at);
            if (poke_at > 0) data_in = 16'($urandom);
            if (valid[0]) begin
                lat = n; got = rd0; nv++;
                break;
            end
        end
        req[0] = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (valid[0]) nv++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 3'b000; data_in = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({scl[i], sda_o[i], sda_oe[i], valid[i], busy[i]} !== 5'b11100) begin
                n_errors++;
                $display("FAIL reset_outputs dut%0d: scl/o/oe/valid/busy=%b expected 11100", i,
                         {scl[i], sda_o[i], sda_oe[i], valid[i], busy[i]});
            end
        end
        n_checks++;
        if ({rd0, rd1, rd2} !== 24'h0) begin
            n_errors++;
            $display("FAIL reset_rd_data: got %h %h %h expected 00 00 00", rd0, rd1, rd2);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int lat, nv; logic [7:0] got; string exp_s, got_s;
        slave_en = 1'b1; slave_q.delete(); slave_q.push_back(8'hA5);
        run_txn(16'h4211, 0, lat, got, nv);
        exp_s = model_bus(16'h4211, 8'hA5); got_s = tok_str(tok_q);
        n_checks++;
        if (got_s != exp_s) begin n_errors++; $display("FAIL basic_bus: got %s expected %s", got_s, exp_s); end
        n_checks++;
        if (got !== 8'hA5) begin n_errors++; $display("FAIL basic_rd_data: got %h expected a5", got); end
        n_checks++;
        if (lat != model_latency(8)) begin n_errors++; $display("FAIL basic_latency: got %0d expected %0d", lat, model_latency(8)); end
        n_checks++;
        if (nv != 1) begin n_errors++; $display("FAIL basic_valid_count: got %0d expected 1", nv); end
        repeat (10) @(posedge clk);
        #1;
        n_checks++;
        if (rd0 !== 8'hA5) begin n_errors++; $display("FAIL basic_hold: got %h expected a5", rd0); end
    endtask

    task automatic test_id_lsb_no_slave();
        int lat, nv; logic [7:0] got; string exp_s, got_s;
        slave_en = 1'b0;
        run_txn(16'h4300, 0, lat, got, nv);
        exp_s = "S 085 001 P S 087 1ff P "; got_s = tok_str(tok_q);
        n_checks++;
        if (got_s != exp_s) begin n_errors++; $display("FAIL idlsb_bus: got %s expected %s", got_s, exp_s); end
        n_checks++;
        if (got !== 8'hFF) begin n_errors++; $display("FAIL idlsb_rd_data: got %h expected ff", got); end
    endtask

    task automatic test_req_while_busy();
        int lat, nv; logic [7:0] got, sb; logic [15:0] d; string exp_s, got_s;
        d = 16'($urandom); sb = 8'($urandom);
        slave_en = 1'b1; slave_q.delete(); slave_q.push_back(sb);
        run_txn(d, 20, lat, got, nv);
        exp_s = model_bus(d, sb); got_s = tok_str(tok_q);
        n_checks++;
        if (got_s != exp_s) begin n_errors++; $display("FAIL busy_req_bus: got %s expected %s", got_s, exp_s); end
        n_checks++;
        if (got !== sb || lat != model_latency(8)) begin
            n_errors++; $display("FAIL busy_req_result: got %h/%0d expected %h/%0d", got, lat, sb, model_latency(8));
        end
        n_checks++;
        if (nv != 1) begin n_errors++; $display("FAIL busy_req_valid_count: got %0d expected 1", nv); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] vals[$]; int idle_cnt, t1, t2;
        slave_en = 1'b1; slave_q.delete(); slave_q.push_back(8'h3C); slave_q.push_back(8'hC3);
        idle_cnt = 0; t1 = -1; t2 = -1;
        @(negedge clk);
        data_in = 16'($urandom); req[0] = 1'b1;
        for (int n = 0; n <= 1000; n++) begin
            @(posedge clk); #1;
            if (valid[0]) begin
                vals.push_back(rd0);
                if (t1 < 0) t1 = n; else t2 = n;
            end
            if (t1 >= 0 && t2 < 0 && !busy[0]) idle_cnt++;
            if (vals.size() >= 2) break;
        end
        req[0] = 1'b0;
        n_checks++;
        if (vals.size() != 2) begin
            n_errors++; $display("FAIL b2b_count: got %0d pulses expected 2", vals.size());
        end else begin
            n_checks++;
            if (vals[0] !== 8'h3C || vals[1] !== 8'hC3) begin
                n_errors++; $display("FAIL b2b_data: got %h %h expected 3c c3", vals[0], vals[1]);
            end
        end
        n_checks++;
        if (idle_cnt < 1) begin n_errors++; $display("FAIL b2b_idle: got %0d idle cycles expected >=1", idle_cnt); end
        n_checks++;
        if (t2 - t1 != model_latency(8) + 1) begin
            n_errors++; $display("FAIL b2b_spacing: got %0d expected %0d", t2 - t1, model_latency(8) + 1);
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic test_reset_mid_read();
        int lat, nv, nvr; logic [7:0] got, sb; logic [15:0] d; string exp_s, got_s;
        slave_en = 1'b1; slave_q.delete(); slave_q.push_back(8'h5A);
        nvr = 0;
        @(negedge clk);
        data_in = 16'h6A3B; req[0] = 1'b1;
        @(posedge clk); #1;
        req[0] = 1'b0;
        // READ starts 128 clocks after acceptance; bit 4 begins 16 clocks later
        for (int n = 1; n <= 145; n++) begin
            @(posedge clk); #1;
            if (valid[0]) nvr++;
        end
        rst_n = 1'b0;
        #1;
        slave_out = 1'b1;
        n_checks++;
        if ({scl[0], sda_o[0], sda_oe[0], valid[0], busy[0]} !== 5'b11100 || rd0 !== 8'h00) begin
            n_errors++;
            $display("FAIL midreset_outputs: scl/o/oe/valid/busy=%b rd=%h expected 11100 rd=00",
                     {scl[0], sda_o[0], sda_oe[0], valid[0], busy[0]}, rd0);
        end
        repeat (4) begin
            @(posedge clk); #1;
            if (valid[0]) nvr++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            if (valid[0]) nvr++;
        end
        n_checks++;
        if (nvr != 0) begin n_errors++; $display("FAIL midreset_no_valid: got %0d pulses expected 0", nvr); end
        d = 16'($urandom); sb = 8'($urandom);
        slave_q.delete(); slave_q.push_back(sb);
        run_txn(d, 0, lat, got, nv);
        exp_s = model_bus(d, sb); got_s = tok_str(tok_q);
        n_checks++;
        if (got_s != exp_s || got !== sb || lat != model_latency(8)) begin
            n_errors++;
            $display("FAIL midreset_recover: bus %s rd %h lat %0d expected bus %s rd %h lat %0d",
                     got_s, got, lat, exp_s, sb, model_latency(8));
        end
    endtask

    task automatic test_random();
        int lat, nv; logic [7:0] got, sb, exp_rd; logic [15:0] d; string exp_s, got_s;
        for (int t = 0; t < 6; t++) begin
            d = 16'($urandom); sb = 8'($urandom);
            slave_en = 1'($urandom_range(0, 1));
            exp_rd = slave_en ? sb : 8'hFF;
            slave_q.delete(); slave_q.push_back(sb);
            run_txn(d, 0, lat, got, nv);
            exp_s = model_bus(d, exp_rd); got_s = tok_str(tok_q);
            n_checks++;
            if (got_s != exp_s || got !== exp_rd || lat != model_latency(8) || nv != 1) begin
                n_errors++;
                $display("FAIL random_txn%0d: bus %s rd %h lat %0d nv %0d expected bus %s rd %h lat %0d nv 1",
                         t, got_s, got, lat, nv, exp_s, exp_rd, model_latency(8));
            end
        end
    endtask

    task automatic test_gap(input int idx, input int g);
        int lat, run, ph; logic ps, pd, cs, cd; logic [7:0] got;
        lat = -1; run = 0; ph = 0; ps = 1'b1; pd = 1'b1; got = 8'h00;
        @(negedge clk);
        data_in = 16'($urandom); req[idx] = 1'b1;
        @(posedge clk); #1;
        req[idx] = 1'b0;
        for (int n = 1; n <= 800; n++) begin
            @(posedge clk); #1;
            cs = scl[idx];
            cd = sda_oe[idx] ? sda_o[idx] : 1'b1;
            if (ph == 0 && ps && cs && !pd && cd) begin
                ph = 1; run = 1;
            end else if (ph == 1) begin
                if (cs && cd) run++;
                else ph = 2;
            end
            ps = cs; pd = cd;
            if (valid[idx]) begin
                lat = n; got = (idx == 1) ? rd1 : rd2;
                break;
            end
        end
        n_checks++;
        if (lat != model_latency(g)) begin n_errors++; $display("FAIL gap%0d_latency: got %0d expected %0d", g, lat, model_latency(g)); end
        // bus idle-high run: two stop quarters, the gap, two start quarters
        n_checks++;
        if (run != g + 4) begin n_errors++; $display("FAIL gap%0d_high_run: got %0d expected %0d", g, run, g + 4); end
        n_checks++;
        if (got !== 8'hFF) begin n_errors++; $display("FAIL gap%0d_rd_data: got %h expected ff", g, got); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_id_lsb_no_slave();
        test_req_while_busy();
        test_back_to_back();
        test_reset_mid_read();
        test_random();
        test_gap(1, 1);
        test_gap(2, 255);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
